fp_div_iter: RTL

//  Iterative, parametrised IEEE-754 binary divider; sequential successor of the single-cycle fp32 divider.

---
 rtl/fp_div_iter_if.sv | 38 +++
 rtl/fp_div_iter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter_if.sv
// fp_div_iter_if: operand/result handshake bundle for the iterative divider.
// rm exists only when FP_DIV_ROUND_MODES_EN is defined.
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef FP_DIV_ROUND_MODES_EN
  logic [2:0]   rm;
`endif
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [4:0]   flags;
  logic         busy;

  modport master (
    output in_valid, a, b, flush, out_ready,
`ifdef FP_DIV_ROUND_MODES_EN
    output rm,
`endif
    input  in_ready, out_valid, y, flags, busy
  );

  modport slave (
    input  in_valid, a, b, flush, out_ready,
`ifdef FP_DIV_ROUND_MODES_EN
    input  rm,
`endif
    output in_ready, out_valid, y, flags, busy
  );
endinterface

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative restoring IEEE-754 divider with valid/ready.
// FP_DIV_ROUND_MODES_EN adds rm (RNE/RTZ/RDN/RUP/RMM); default is RNE.
module fp_div_iter #(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int ITER_PER_CYC = 1
) (
  input logic          clk,
  input logic          rst_n,
  fp_div_iter_if.slave io
);
  localparam int W    = EXP_W + MAN_W + 1;
  localparam int SW   = MAN_W + 1;
  localparam int RW   = MAN_W + 2;
  localparam int QB   = MAN_W + 3;
  localparam int XW   = EXP_W + 2;
  localparam int NCYC = QB / ITER_PER_CYC;
  localparam int CW   = $clog2(NCYC + 1);
  localparam int LZW  = $clog2(SW + 1);

  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] BIAS =
    XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX =
    XW'((1 << EXP_W) - 2);
  localparam logic [XW-1:0] SH_CAP   = XW'(QB);
  localparam logic [CW-1:0] CNT_INIT = CW'(NCYC - 1);

  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-2:0] INF_M =
    {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] MAX_M =
    {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  localparam logic [W-1:0] QBIT = W'(1) << (MAN_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, INF_M} | QBIT;

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_NORM, S_DIV, S_ROUND, S_DONE
  } state_t;

  state_t                 state;
  logic [W-1:0]           a_r, b_r;
  logic                   sign_r;
  logic [SW-1:0]          mb_r;
  logic [RW-1:0]          rem_r;
  logic [QB-1:0]          q_r;
  logic signed [XW-1:0]   exp_r;
  logic [CW-1:0]          cnt_r;
  logic                   out_valid_r;
  logic [W-1:0]           y_r;
  logic [4:0]             flags_r;
`ifdef FP_DIV_ROUND_MODES_EN
  logic [2:0]             rm_r;
`else
  wire logic [2:0]        rm_r = 3'b000;
`endif

  function automatic logic spec_op(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EONES) || (x[W-2:0] == '0);
  endfunction

  function automatic logic [LZW-1:0] lzc(
    input logic [SW-1:0] v
  );
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_snan, b_snan;
  logic a_inf, b_inf, a_zero, b_zero;

  assign ea     = a_r[W-2:MAN_W];
  assign eb     = b_r[W-2:MAN_W];
  assign fa     = a_r[MAN_W-1:0];
  assign fb     = b_r[MAN_W-1:0];
  assign a_nan  = (ea == EONES) && (fa != '0);
  assign b_nan  = (eb == EONES) && (fb != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (ea == EONES) && (fa == '0);
  assign b_inf  = (eb == EONES) && (fb == '0);
  assign a_zero = (ea == '0) && (fa == '0);
  assign b_zero = (eb == '0) && (fb == '0);

  logic [W-1:0] sp_y;
  logic [4:0]   sp_f;

  always_comb begin
    sp_y = '0;
    sp_f = '0;
    if (a_nan || b_nan) begin
      sp_y    = a_nan ? (a_r | QBIT) : (b_r | QBIT);
      sp_f[4] = a_snan | b_snan;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      sp_y    = QNAN;
      sp_f[4] = 1'b1;
    end else if (a_inf) begin
      sp_y = {sign_r, INF_M};
    end else if (b_zero) begin
      sp_y    = {sign_r, INF_M};
      sp_f[3] = 1'b1;
    end else begin
      sp_y = {sign_r, {(W-1){1'b0}}};
    end
  end

  // Subnormals get a leading-zero shift and a matching exponent debit.
  logic [SW-1:0]        sig_a, sig_b, ma_n, mb_n;
  logic [LZW-1:0]       lz_a, lz_b;
  logic signed [XW-1:0] ea_eff, eb_eff, exp_n;

  always_comb begin
    sig_a  = {ea != '0, fa};
    sig_b  = {eb != '0, fb};
    lz_a   = lzc(sig_a);
    lz_b   = lzc(sig_b);
    ma_n   = sig_a << lz_a;
    mb_n   = sig_b << lz_b;
    ea_eff = (ea == '0) ? ONE - $signed(XW'(lz_a))
                        : $signed({2'b00, ea});
    eb_eff = (eb == '0) ? ONE - $signed(XW'(lz_b))
                        : $signed({2'b00, eb});
    exp_n  = ea_eff - eb_eff + BIAS;
  end

  logic [RW-1:0] rem_c;
  logic [QB-1:0] q_c;
  logic [RW:0]   d_c;

  always_comb begin
    rem_c = rem_r;
    q_c   = q_r;
    d_c   = '0;
    for (int k = 0; k < ITER_PER_CYC; k++) begin
      d_c   = {1'b0, rem_c} - {2'b00, mb_r};
      q_c   = {q_c[QB-2:0], ~d_c[RW]};
      rem_c = d_c[RW] ? rem_c << 1 : d_c[RW-1:0] << 1;
    end
  end

  logic                 q_hi, g_n, s_n, tiny;
  logic [SW-1:0]        sig_n, sig_p;
  logic signed [XW-1:0] e_n, sh_s, e_r;
  logic [XW-1:0]        sh_u;
  logic [2*SW+1:0]      xw;
  logic                 g_p, s_p, inex, inc, ovf, ovf_inf;
  logic [SW:0]          sum;
  logic [MAN_W-1:0]     sig_r;
  logic [W-1:0]         rd_y;
  logic [4:0]           rd_f;

  always_comb begin
    q_hi  = q_r[QB-1];
    sig_n = q_hi ? q_r[QB-1:2] : q_r[QB-2:1];
    g_n   = q_hi ? q_r[1] : q_r[0];
    s_n   = (q_hi & q_r[0]) | (|rem_r);
    e_n   = q_hi ? exp_r : exp_r - ONE;
    tiny  = e_n < ONE;
    sh_s  = ONE - e_n;
    sh_u  = tiny ? sh_s : '0;
    if (sh_u > SH_CAP) sh_u = SH_CAP;
    // Denormalising shift; everything pushed past guard becomes sticky.
    xw    = {sig_n, g_n, {(SW+1){1'b0}}} >> sh_u;
    sig_p = xw[2*SW+1:SW+2];
    g_p   = xw[SW+1];
    s_p   = s_n | (|xw[SW:0]);
    inex  = g_p | s_p;
    case (rm_r)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_r & inex;
      3'b011:  inc = ~sign_r & inex;
      3'b100:  inc = g_p;
      default: inc = g_p & (s_p | sig_p[0]);
    endcase
    case (rm_r)
      3'b001:  ovf_inf = 1'b0;
      3'b010:  ovf_inf = sign_r;
      3'b011:  ovf_inf = ~sign_r;
      default: ovf_inf = 1'b1;
    endcase
    sum = {1'b0, sig_p} + (SW+1)'(inc);
    if (sum[SW]) begin
      sig_r = sum[SW-1:1];
      e_r   = e_n + ONE;
    end else begin
      sig_r = sum[MAN_W-1:0];
      e_r   = tiny ? (sum[SW-1] ? ONE : '0) : e_n;
    end
    ovf = !tiny && (e_r > EMAX);
    if (ovf) begin
      rd_y = {sign_r, ovf_inf ? INF_M : MAX_M};
      rd_f = 5'b00101;
    end else begin
      rd_y = {sign_r, e_r[EXP_W-1:0], sig_r};
      rd_f = {3'b000, tiny & inex, inex};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sign_r      <= 1'b0;
      mb_r        <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      exp_r       <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      flags_r     <= '0;
`ifdef FP_DIV_ROUND_MODES_EN
      rm_r        <= '0;
`endif
    end else if (io.flush) begin
      state       <= S_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (io.in_valid) begin
          a_r    <= io.a;
          b_r    <= io.b;
          sign_r <= io.a[W-1] ^ io.b[W-1];
`ifdef FP_DIV_ROUND_MODES_EN
          rm_r   <= io.rm;
`endif
          state  <= (spec_op(io.a) || spec_op(io.b))
                    ? S_SPECIAL : S_NORM;
        end
        S_SPECIAL: begin
          y_r         <= sp_y;
          flags_r     <= sp_f;
          out_valid_r <= 1'b1;
          state       <= S_DONE;
        end
        S_NORM: begin
          mb_r  <= mb_n;
          rem_r <= {1'b0, ma_n};
          q_r   <= '0;
          exp_r <= exp_n;
          cnt_r <= CNT_INIT;
          state <= S_DIV;
        end
        S_DIV: begin
          rem_r <= rem_c;
          q_r   <= q_c;
          if (cnt_r == '0) state <= S_ROUND;
          else cnt_r <= cnt_r - 1'b1;
        end
        S_ROUND: begin
          y_r         <= rd_y;
          flags_r     <= rd_f;
          out_valid_r <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: if (io.out_ready) begin
          out_valid_r <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == S_IDLE);
  assign io.busy      = (state != S_IDLE);
  assign io.out_valid = out_valid_r;
  assign io.y         = y_r;
  assign io.flags     = flags_r;
endmodule
